// File: rtl/fp_pkg.sv
// Shared FP adder definitions: field widths, special encodings, FSM states.
package fp_pkg;

    localparam int unsigned EXP_W  = 8;
    localparam int unsigned FRAC_W = 23;
    localparam int unsigned BIAS   = 127;
    localparam int unsigned SIG_W  = FRAC_W + 4;

    localparam logic [31:0]      QNAN    = 32'h7FC0_0000;
    localparam logic [31:0]      PINF    = 32'h7F80_0000;
    localparam logic [EXP_W-1:0] EXP_MAX = '1;

    typedef enum logic [2:0] {
        IDLE,
        ALIGN,
        ADD,
        NORM,
        WB
    } fpState_t;

    typedef struct packed {
        logic              sign;
        logic [EXP_W-1:0]  exp;
        logic [FRAC_W-1:0] frac;
    } fp32_t;

    function automatic logic [31:0] signedInf(input logic sign);
        return PINF | {sign, 31'b0};
    endfunction

endpackage

// File: rtl/fp_lzc27.sv
// Leading-zero counter for the 27-bit normalisation datapath.
module fp_lzc27
    import fp_pkg::*;
(
    input  logic [SIG_W-1:0] value,
    output logic [4:0]       count,
    output logic             allZero
);

    always_comb begin
        count = 5'(SIG_W);
        for (int unsigned i = 0; i < SIG_W; i++) begin
            if (value[i]) begin
                count = 5'(SIG_W - 1 - i);
            end
        end
        allZero = ~|value;
    end

endmodule

// File: rtl/fp_add_unit.sv
// Multi-cycle single-precision adder/subtractor writing the FP register file.
// Build option: define FPADD_RNE_EN for round-to-nearest-even; default truncates.
module fp_add_unit
    import fp_pkg::*;
(
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic        Start,
    input  logic [31:0] OpA,
    input  logic [31:0] OpB,
    input  logic        Sub,
    input  logic [4:0]  DestReg,
    output logic        Busy,
    output logic        Done,
    output logic [31:0] WriteData,
    output logic [4:0]  WriteRegister,
    output logic        RegWrite
);

    localparam int unsigned XW = EXP_W + 2;

    fpState_t state, stateNext;

    fp32_t      opAQ, opBQ;
    logic       subQ;
    logic [4:0] destQ;

    logic [SIG_W-1:0] bigQ, smallQ;
    logic [EXP_W-1:0] expQ;
    logic             signQ, effSubQ, specialQ;
    logic [31:0]      specialValQ;
    logic [SIG_W:0]   sumQ;

    logic [FRAC_W:0]  aSig, bSig, bigSig, smallSig;
    logic [EXP_W-1:0] bigExp, smallExp, expDiff;
    logic [4:0]       shAmt;
    logic [SIG_W-1:0] smallExt, shMask, smallShifted;
    logic             aNan, bNan, aInf, bInf, bSignEff, bigSign, stickyLost;
    logic             isSpecial;
    logic [31:0]      specialVal;

    logic [4:0]        lzCount;
    logic              lowZero, sumZero;
    logic [SIG_W-1:0]  normSig;
    logic [XW-1:0]     normExp, finalExp;
    logic [FRAC_W-1:0] finalFrac;
    logic [31:0]       result;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext = state;
        Busy      = (state != IDLE);
        Done      = 1'b0;
        RegWrite  = 1'b0;
        case (state)
            IDLE:    if (Start) stateNext = ALIGN;
            ALIGN:   stateNext = ADD;
            ADD:     stateNext = NORM;
            NORM:    stateNext = WB;
            WB: begin
                stateNext = IDLE;
                Done      = 1'b1;
                RegWrite  = (WriteRegister != '0);
            end
            default: stateNext = IDLE;
        endcase
    end

    // Denormals are flushed by giving them a zero significand; exponent is already 0.
    always_comb begin
        aSig     = (opAQ.exp != '0) ? {1'b1, opAQ.frac} : '0;
        bSig     = (opBQ.exp != '0) ? {1'b1, opBQ.frac} : '0;
        bSignEff = opBQ.sign ^ subQ;
        aNan     = (opAQ.exp == EXP_MAX) && (opAQ.frac != '0);
        bNan     = (opBQ.exp == EXP_MAX) && (opBQ.frac != '0);
        aInf     = (opAQ.exp == EXP_MAX) && (opAQ.frac == '0);
        bInf     = (opBQ.exp == EXP_MAX) && (opBQ.frac == '0);

        if ({opAQ.exp, aSig} >= {opBQ.exp, bSig}) begin
            bigSig   = aSig;
            bigExp   = opAQ.exp;
            bigSign  = opAQ.sign;
            smallSig = bSig;
            smallExp = opBQ.exp;
        end else begin
            bigSig   = bSig;
            bigExp   = opBQ.exp;
            bigSign  = bSignEff;
            smallSig = aSig;
            smallExp = opAQ.exp;
        end

        expDiff      = bigExp - smallExp;
        shAmt        = (expDiff > EXP_W'(26)) ? 5'd26 : expDiff[4:0];
        smallExt     = {smallSig, 3'b000};
        shMask       = (SIG_W'(1) << shAmt) - SIG_W'(1);
        stickyLost   = |(smallExt & shMask);
        smallShifted = (smallExt >> shAmt) | {{(SIG_W-1){1'b0}}, stickyLost};

        isSpecial  = 1'b1;
        specialVal = '0;
        if (aNan || bNan) begin
            specialVal = QNAN;
        end else if (aInf && bInf) begin
            specialVal = (opAQ.sign != bSignEff) ? QNAN : signedInf(opAQ.sign);
        end else if (aInf) begin
            specialVal = signedInf(opAQ.sign);
        end else if (bInf) begin
            specialVal = signedInf(bSignEff);
        end else begin
            isSpecial = 1'b0;
        end
    end

    fp_lzc27 uLzc (
        .value   (sumQ[SIG_W-1:0]),
        .count   (lzCount),
        .allZero (lowZero)
    );

    assign sumZero = lowZero && !sumQ[SIG_W];

    always_comb begin
        if (sumQ[SIG_W]) begin
            normSig = {sumQ[SIG_W:2], sumQ[1] | sumQ[0]};
            normExp = {2'b00, expQ} + XW'(1);
        end else begin
            normSig = sumQ[SIG_W-1:0] << lzCount;
            normExp = {2'b00, expQ} - {{(XW-5){1'b0}}, lzCount};
        end
    end

`ifdef FPADD_RNE_EN
    logic              roundUp;
    logic [FRAC_W+1:0] mantRnd;

    always_comb begin
        roundUp = normSig[2] & (normSig[3] | normSig[1] | normSig[0]);
        mantRnd = {1'b0, normSig[SIG_W-1:3]} + {{(FRAC_W+1){1'b0}}, roundUp};
        if (mantRnd[FRAC_W+1]) begin
            finalFrac = mantRnd[FRAC_W:1];
            finalExp  = normExp + XW'(1);
        end else begin
            finalFrac = mantRnd[FRAC_W-1:0];
            finalExp  = normExp;
        end
    end
`else
    logic unusedBits;

    always_comb begin
        finalFrac  = normSig[SIG_W-2:3];
        finalExp   = normExp;
        unusedBits = ^{normSig[SIG_W-1], normSig[2:0]};
    end
`endif

    // A negative exponent wraps and sets the top bit, so it reads as underflow.
    always_comb begin
        if (specialQ) begin
            result = specialValQ;
        end else if (sumZero) begin
            result = {signQ & ~effSubQ, 31'b0};
        end else if (finalExp[XW-1] || (finalExp == '0)) begin
            result = {signQ, 31'b0};
        end else if (finalExp >= {2'b00, EXP_MAX}) begin
            result = signedInf(signQ);
        end else begin
            result = {signQ, finalExp[EXP_W-1:0], finalFrac};
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            opAQ          <= '0;
            opBQ          <= '0;
            subQ          <= 1'b0;
            destQ         <= '0;
            bigQ          <= '0;
            smallQ        <= '0;
            expQ          <= '0;
            signQ         <= 1'b0;
            effSubQ       <= 1'b0;
            specialQ      <= 1'b0;
            specialValQ   <= '0;
            sumQ          <= '0;
            WriteData     <= '0;
            WriteRegister <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (Start) begin
                        opAQ  <= OpA;
                        opBQ  <= OpB;
                        subQ  <= Sub;
                        destQ <= DestReg;
                    end
                end
                ALIGN: begin
                    bigQ        <= {bigSig, 3'b000};
                    smallQ      <= smallShifted;
                    expQ        <= bigExp;
                    signQ       <= bigSign;
                    effSubQ     <= opAQ.sign ^ bSignEff;
                    specialQ    <= isSpecial;
                    specialValQ <= specialVal;
                end
                ADD: begin
                    sumQ <= effSubQ ? ({1'b0, bigQ} - {1'b0, smallQ})
                                    : ({1'b0, bigQ} + {1'b0, smallQ});
                end
                NORM: begin
                    WriteData     <= result;
                    WriteRegister <= destQ;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fp_add_unit.sv
// Scoreboard bench for fp_add_unit: directed vectors, decoupled monitor.
module tb_fp_add_unit;

    logic        Clk = 1'b0;
    logic        Reset_n = 1'b0;
    logic        Start = 1'b0;
    logic [31:0] OpA = '0;
    logic [31:0] OpB = '0;
    logic        Sub = 1'b0;
    logic [4:0]  DestReg = '0;
    logic        Busy, Done, RegWrite;
    logic [31:0] WriteData;
    logic [4:0]  WriteRegister;

    int unsigned errors = 0;
    int unsigned checks = 0;
    int unsigned cycCnt = 0;
    int unsigned doneSeen = 0;

    typedef struct {
        logic [31:0] data;
        logic [4:0]  dest;
        logic        regWr;
        logic        chkData;
        int unsigned doneCyc;
    } expItem_t;

    expItem_t sb[$];
    expItem_t monItem;

`ifdef FPADD_RNE_EN
    localparam logic [31:0] EXP_RND_A = 32'h3F80_0001;
    localparam logic [31:0] EXP_RND_B = 32'h3F80_0002;
`else
    localparam logic [31:0] EXP_RND_A = 32'h3F80_0000;
    localparam logic [31:0] EXP_RND_B = 32'h3F80_0001;
`endif

    fp_add_unit dut (
        .Clk           (Clk),
        .Reset_n       (Reset_n),
        .Start         (Start),
        .OpA           (OpA),
        .OpB           (OpB),
        .Sub           (Sub),
        .DestReg       (DestReg),
        .Busy          (Busy),
        .Done          (Done),
        .WriteData     (WriteData),
        .WriteRegister (WriteRegister),
        .RegWrite      (RegWrite)
    );

    always #5 Clk = ~Clk;

    always @(posedge Clk) cycCnt <= cycCnt + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cycCnt);
        end
    endtask

    always @(negedge Clk) begin
        if (Reset_n) begin
            check("regwrite_outside_wb", {31'b0, RegWrite & ~Done}, 32'h0);
            if (Done) begin
                doneSeen++;
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: got Done=1 at cycle %0d, expected no pending op", cycCnt);
                end else begin
                    monItem = sb.pop_front();
                    check("latency", cycCnt, monItem.doneCyc);
                    check("write_register", {27'b0, WriteRegister}, {27'b0, monItem.dest});
                    check("reg_write", {31'b0, RegWrite}, {31'b0, monItem.regWr});
                    if (monItem.chkData) check("write_data", WriteData, monItem.data);
                end
            end
        end
    end

    task automatic waitIdle();
        int unsigned guard = 0;
        while (Busy && guard < 20) begin
            @(negedge Clk);
            guard++;
        end
        if (Busy) begin
            checks++;
            errors++;
            $display("FAIL idle_timeout: got Busy=1 after %0d cycles, expected 0", guard);
        end
    endtask

    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic s,
                         input logic [4:0] d, input logic [31:0] expData);
        waitIdle();
        OpA     = a;
        OpB     = b;
        Sub     = s;
        DestReg = d;
        Start   = 1'b1;
        sb.push_back('{expData, d, d != 5'd0, d != 5'd0, cycCnt + 4});
        @(posedge Clk);
        #1;
        Start   = 1'b0;
        OpA     = ~a;
        OpB     = ~b;
        Sub     = ~s;
        DestReg = ~d;
        check("busy_after_start", {31'b0, Busy}, 32'h1);
        @(negedge Clk);
    endtask

    task automatic drain();
        int unsigned guard = 0;
        while (sb.size() != 0 && guard < 40) begin
            @(negedge Clk);
            guard++;
        end
        check("drain_pending", sb.size(), 32'h0);
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] burstExp [3];
        int unsigned doneBefore;
        burstExp = '{32'h3F80_0000, 32'h4200_0000, 32'h4480_0000};

        repeat (2) @(negedge Clk);
        check("rst_busy", {31'b0, Busy}, 32'h0);
        check("rst_done", {31'b0, Done}, 32'h0);
        check("rst_regwrite", {31'b0, RegWrite}, 32'h0);
        check("rst_write_data", WriteData, 32'h0);
        check("rst_write_register", {27'b0, WriteRegister}, 32'h0);

        // First Start accepted on the first edge after reset release.
        OpA     = 32'h3F80_0000;
        OpB     = 32'h3F80_0000;
        Sub     = 1'b0;
        DestReg = 5'd5;
        Start   = 1'b1;
        sb.push_back('{32'h4000_0000, 5'd5, 1'b1, 1'b1, cycCnt + 4});
        Reset_n = 1'b1;
        @(posedge Clk);
        #1;
        Start = 1'b0;
        OpA   = '0;
        @(negedge Clk);

        issue(32'h3F80_0000, 32'h3F80_0000, 1'b1, 5'd3,  32'h0000_0000);
        issue(32'h7F80_0000, 32'hFF80_0000, 1'b0, 5'd4,  32'h7FC0_0000);
        issue(32'h3F80_0000, 32'h33C0_0000, 1'b0, 5'd6,  EXP_RND_A);
        issue(32'h7F7F_FFFF, 32'h7F7F_FFFF, 1'b0, 5'd7,  32'h7F80_0000);
        issue(32'h4040_0000, 32'h3F80_0000, 1'b0, 5'd0,  32'h4080_0000);
        issue(32'h7F80_0001, 32'h3F80_0000, 1'b0, 5'd8,  32'h7FC0_0000);
        issue(32'h3F80_0000, 32'h7F80_0000, 1'b1, 5'd9,  32'hFF80_0000);
        issue(32'h4040_0000, 32'h3F80_0000, 1'b1, 5'd10, 32'h4000_0000);
        issue(32'h0000_0001, 32'h0000_0001, 1'b0, 5'd11, 32'h0000_0000);
        issue(32'h80C0_0000, 32'h0080_0000, 1'b0, 5'd12, 32'h8000_0000);
        issue(32'hBF80_0000, 32'h4000_0000, 1'b0, 5'd13, 32'h3F80_0000);
        issue(32'h3F80_0000, 32'h3380_0000, 1'b0, 5'd14, 32'h3F80_0000);
        issue(32'h3F80_0001, 32'h3380_0000, 1'b0, 5'd15, EXP_RND_B);
        issue(32'h3F80_0000, 32'h3380_0000, 1'b1, 5'd16, 32'h3F7F_FFFF);
        drain();

        // Start held high with new operands each cycle: only IDLE cycles capture.
        waitIdle();
        for (int k = 0; k < 11; k++) begin
            OpA     = 32'h3F80_0000 + (32'(k) << 23);
            OpB     = '0;
            Sub     = 1'b0;
            DestReg = 5'(k + 1);
            Start   = 1'b1;
            if (k % 5 == 0) begin
                sb.push_back('{burstExp[k / 5], 5'(k + 1), 1'b1, 1'b1, cycCnt + 4});
            end
            @(negedge Clk);
        end
        Start = 1'b0;
        drain();

        // Reset while the operation is in ADD.
        waitIdle();
        OpA     = 32'h3F80_0000;
        OpB     = 32'h3F80_0000;
        Sub     = 1'b0;
        DestReg = 5'd20;
        Start   = 1'b1;
        @(posedge Clk);
        #1;
        Start = 1'b0;
        @(posedge Clk);
        #2;
        doneBefore = doneSeen;
        Reset_n = 1'b0;
        #1;
        check("inflight_rst_busy", {31'b0, Busy}, 32'h0);
        check("inflight_rst_done", {31'b0, Done}, 32'h0);
        check("inflight_rst_regwrite", {31'b0, RegWrite}, 32'h0);
        check("inflight_rst_write_data", WriteData, 32'h0);
        check("inflight_rst_write_register", {27'b0, WriteRegister}, 32'h0);
        @(negedge Clk);
        @(negedge Clk);
        Reset_n = 1'b1;
        repeat (8) @(negedge Clk);
        check("no_done_after_reset", doneSeen, doneBefore);

        issue(32'h3F80_0000, 32'h4000_0000, 1'b0, 5'd1, 32'h4040_0000);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
